store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- Data-memory write path for the RV32I core; counterpart of the load path.
- Takes an issued S-type store (SB/SH/SW), forms the effective address and builds byte enables and lane-aligned write data.
- Drives a word-aligned write handshake to data memory. Misaligned stores that cross a word boundary are split into two aligned beats.
- Reports completion or error back to the core.

Parameters:
- ACK_TIMEOUT, 16, max cycles a beat waits for d_ack before aborting with err (valid range 1..255).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  issue strobe; sampled only in IDLE
- opcode  input  7  instruction opcode
- funct3  input  3  store width select
- imm  input  12  S-type immediate {inst[31:25],inst[11:7]}
- in1  input  32  base register rs1
- in2  input  32  store data rs2
- busy  output  1  high from cycle after accepted start until done/err cycle inclusive
- done  output  1  one-cycle pulse, store completed
- err  output  1  one-cycle pulse (with done), illegal op or ack timeout
- d_addr  output  32  word-aligned write address (bits[1:0]=0)
- d_wdata  output  32  lane-aligned write data
- d_be  output  4  byte enables, bit i = byte lane i
- d_we  output  1  write request, held until d_ack
- d_ack  input  1  memory accepts current beat this cycle

Behaviour:
- Reset: synchronous, active-high; state IDLE. busy, done, err, d_we = 0; d_addr, d_wdata = 0; d_be = 0; timeout counter = 0. Reset mid-beat aborts: d_we low after the edge, no done/err.
- Accept: in IDLE with start=1, register opcode/funct3/ea/in2. Start outside IDLE is ignored, no queueing.
- Legality: opcode must be 7'b0100011 and funct3 one of 000 (SB), 001 (SH), 010 (SW).
  - Illegal → RESP with err=1, no memory beat.
- Effective address: ea = in1 + sign-extended imm, modulo 2^32. off = ea[1:0]. size = 1/2/4 bytes.
- Lane alignment:
  - mask8 = ((1<<size)-1) << off.
  - wide64 = {32'b0, in2 masked to size} << (8*off).
  - split = |mask8[7:4].
- Beat0: d_addr = {ea[31:2],2'b00}; d_be = mask8[3:0]; d_wdata = wide64[31:0].
- Beat1: d_addr = beat0 address + 4 (0xFFFFFFFC wraps to 0x00000000); d_be = mask8[7:4]; d_wdata = wide64[63:32].
- Unused byte lanes of d_wdata are driven 0.
- FSM:
  - IDLE → BEAT0 (legal start), or IDLE → RESP (illegal start).
  - BEAT0: d_we=1. On d_ack: BEAT1 if split, else RESP.
  - BEAT1: d_we=1. On d_ack: RESP.
  - RESP: done=1; err per cause. → IDLE next cycle.
- Handshake: d_addr/d_wdata/d_be/d_we stable while waiting. A beat completes on the cycle d_we&&d_ack. d_we drops or changes beat on the following edge.
- Timeout: counter clears on beat entry and increments each cycle without d_ack. Reaching ACK_TIMEOUT → RESP with err=1; beat1 is not issued.
- Latency, aligned store with immediate ack: start at cycle N, d_we at N+1, done at N+2. Split store: done at N+3.
- done and err are registered outputs, never asserted in the same cycle as d_we.

Decomposition:
- Package store_pkg:
  - OP_STORE = 7'b0100011.
  - F3_SB/F3_SH/F3_SW.
  - enum st_state_e {IDLE, BEAT0, BEAT1, RESP}.
  - Function size_mask(funct3).
- Sub-module store_lane_align (combinational): inputs off, funct3, data; outputs mask8[7:0], wide64[63:0], split. Unit-testable on its own.

Test Plan:
- SW in1=0x1000, imm=0x004, in2=0xDEADBEEF, d_ack tied 1 → one beat: addr 0x1004, be 4'b1111, wdata 0xDEADBEEF; done at N+2, err=0.
- SB in1=0x2003, imm=0, in2=0x000000A5 → addr 0x2000, be 4'b1000, wdata 0xA5000000.
- SH in1=0x3000, imm=12'hFFF (-1) → ea 0x2FFF, split. Beat0: addr 0x2FFC, be 1000, wdata byte3=in2[7:0]. Beat1: addr 0x3000, be 0001, wdata byte0=in2[15:8]. done at N+3.
- SW at ea 0xFFFFFFFE with in2=0x11223344 → beat0 addr 0xFFFFFFFC, be 1100, wdata 0x33440000. Beat1 addr 0x00000000, be 0011, wdata 0x00001122.
- d_ack held 0 → signals stable for 16 cycles, then done=1, err=1, d_we=0. Separately, funct3=011 → done+err at N+1, d_we never asserted.
- rst asserted mid-BEAT0 while d_ack=0 → next cycle all outputs 0, no done. Start during busy is ignored.

Source files
------------

// File: rtl/store_pkg.sv
// Shared constants, FSM state type and width helpers for the RV32I store path.
package store_pkg;

    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } st_state_e;

    // Byte mask for the access width before lane shifting (SB=1, SH=2, SW=4 bytes).
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3)
            F3_SB:   return 4'b0001;
            F3_SH:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_store_f3(input logic [2:0] funct3);
        return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Places store data and byte enables into the two word lanes touched by an access
// at byte offset off; split flags an access that spills into the next word.
module store_lane_align
    import store_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] data,
    output logic [7:0]  mask8,
    output logic [63:0] wide64,
    output logic        split
);

    logic [3:0]  bmask;
    logic [31:0] dmask;

    // NOTE: every output of a combinational block is assigned on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        bmask  = size_mask(funct3);
        dmask  = {{8{bmask[3]}}, {8{bmask[2]}}, {8{bmask[1]}}, {8{bmask[0]}}};
        mask8  = {4'b0000, bmask} << off;
        wide64 = {32'd0, data & dmask} << {off, 3'b000};
        split  = |mask8[7:4];
    end

endmodule

// File: rtl/store_unit.sv
// RV32I data-memory write path: forms the effective address, lane-aligns the data
// and issues one or two word-aligned write beats, reporting done/err to the core.
module store_unit
    import store_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [11:0] imm,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] d_addr,
    output logic [31:0] d_wdata,
    output logic [3:0]  d_be,
    output logic        d_we,
    input  logic        d_ack
);

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    st_state_e   state, next_state;
    logic [31:0] ea;
    logic [7:0]  mask8;
    logic [63:0] wide64;
    logic        split;
    logic        legal;
    logic        err_next;
    logic        tmo_hit;
    logic        accept;
    logic        to_beat1;

    // Second-beat image captured at accept so the beat switch is a plain reload.
    logic        split_q;
    logic [31:0] hi_addr;
    logic [31:0] hi_wdata;
    logic [3:0]  hi_be;
    logic [7:0]  tmo_cnt;

    assign ea       = in1 + {{20{imm[11]}}, imm};
    assign legal    = (opcode == OP_STORE) && is_store_f3(funct3);
    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign accept   = (state == IDLE) && start && legal;
    assign to_beat1 = (state == BEAT0) && (next_state == BEAT1);

    store_lane_align u_align (
        .off    (ea[1:0]),
        .funct3 (funct3),
        .data   (in2),
        .mask8  (mask8),
        .wide64 (wide64),
        .split  (split)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = legal ? BEAT0 : RESP;
                    err_next   = !legal;
                end
            end
            BEAT0: begin
                if (d_ack) begin
                    next_state = split_q ? BEAT1 : RESP;
                end else if (tmo_hit) begin
                    next_state = RESP;
                    err_next   = 1'b1;
                end
            end
            BEAT1: begin
                if (d_ack) begin
                    next_state = RESP;
                end else if (tmo_hit) begin
                    next_state = RESP;
                    err_next   = 1'b1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake and response outputs are registered from the next state, so
    // done/err can never overlap d_we and the bus holds steady while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            d_we     <= 1'b0;
            d_addr   <= '0;
            d_wdata  <= '0;
            d_be     <= '0;
            tmo_cnt  <= '0;
            split_q  <= 1'b0;
            hi_addr  <= '0;
            hi_wdata <= '0;
            hi_be    <= '0;
        end else begin
            busy <= (next_state != IDLE);
            done <= (next_state == RESP);
            err  <= err_next;
            d_we <= (next_state == BEAT0) || (next_state == BEAT1);

            if (next_state != state) begin
                tmo_cnt <= '0;
            end else if ((state == BEAT0) || (state == BEAT1)) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end

            if (accept) begin
                d_addr   <= {ea[31:2], 2'b00};
                d_be     <= mask8[3:0];
                d_wdata  <= wide64[31:0];
                hi_addr  <= {ea[31:2], 2'b00} + 32'd4;
                hi_be    <= mask8[7:4];
                hi_wdata <= wide64[63:32];
                split_q  <= split;
            end else if (to_beat1) begin
                d_addr  <= hi_addr;
                d_be    <= hi_be;
                d_wdata <= hi_wdata;
            end
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed cases plus random stores checked
// against a byte-level memory-write model.
module tb_store_unit;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] imm;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_we;
    logic        d_ack;

    int checks = 0;
    int errors = 0;

    store_unit #(.ACK_TIMEOUT(T)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .opcode  (opcode),
        .funct3  (funct3),
        .imm     (imm),
        .in1     (in1),
        .in2     (in2),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_be    (d_be),
        .d_we    (d_we),
        .d_ack   (d_ack)
    );

    always #5 clk = ~clk;

    // Issues one store and follows it to completion. The model walks the
    // accessed bytes one address at a time and groups them by word.
    task automatic do_store(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic [11:0] im, input logic [31:0] base,
                            input logic [31:0] data, input int ack_delay, input bit poke);
        logic [31:0] ea;
        logic [31:0] ba;
        logic [31:0] exp_addr[2];
        logic [3:0]  exp_be[2];
        logic [31:0] exp_data[2];
        bit          legal;
        bit          exp_err;
        bit          finished;
        int          size, nb, bi, waitc, exp_done, exp_bi, lane;

        legal = (op == 7'b0100011) && (f3 <= 3'd2);
        ea    = base + {{20{im[11]}}, im};
        size  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        nb    = 0;
        for (int i = 0; i < 2; i++) begin
            exp_addr[i] = '0;
            exp_be[i]   = '0;
            exp_data[i] = '0;
        end
        if (legal) begin
            for (int k = 0; k < size; k++) begin
                ba = ea + 32'(k);
                if (nb == 0 || {ba[31:2], 2'b00} != exp_addr[nb-1]) begin
                    exp_addr[nb] = {ba[31:2], 2'b00};
                    nb++;
                end
                lane = int'(ba[1:0]);
                exp_be[nb-1][lane]           = 1'b1;
                exp_data[nb-1][8*lane +: 8]  = data[8*k +: 8];
            end
        end
        if (!legal) begin
            exp_err = 1'b1; exp_done = 1; exp_bi = 0;
        end else if (ack_delay >= T) begin
            exp_err = 1'b1; exp_done = 1 + T; exp_bi = 0;
        end else begin
            exp_err = 1'b0; exp_done = 1 + nb * (ack_delay + 1); exp_bi = nb;
        end

        @(negedge clk);
        opcode = op; funct3 = f3; imm = im; in1 = base; in2 = data;
        start = 1'b1; d_ack = 1'b0;
        finished = 1'b0; bi = 0; waitc = 0;

        for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0;
                in1 = ~base; in2 = ~data; imm = ~im;
            end
            if (poke && cyc == 2) begin
                start = 1'b1; opcode = 7'b0100011; funct3 = 3'b010;
            end else if (poke && cyc == 3) begin
                start = 1'b0;
            end

            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cyc%0d: got %b expected 1", name, cyc, busy);
            end

            if (d_we === 1'b1) begin
                checks++;
                if (bi >= nb) begin
                    errors++;
                    $display("FAIL %s unexpected beat%0d cyc%0d addr %h", name, bi, cyc, d_addr);
                end else begin
                    checks += 3;
                    if (d_addr !== exp_addr[bi]) begin
                        errors++;
                        $display("FAIL %s addr beat%0d: got %h expected %h", name, bi, d_addr, exp_addr[bi]);
                    end
                    if (d_be !== exp_be[bi]) begin
                        errors++;
                        $display("FAIL %s be beat%0d: got %b expected %b", name, bi, d_be, exp_be[bi]);
                    end
                    if (d_wdata !== exp_data[bi]) begin
                        errors++;
                        $display("FAIL %s wdata beat%0d: got %h expected %h", name, bi, d_wdata, exp_data[bi]);
                    end
                end
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done with d_we cyc%0d: got %b expected 0", name, cyc, done);
                end
                if (waitc == ack_delay) begin
                    d_ack = 1'b1; bi++; waitc = 0;
                end else begin
                    d_ack = 1'b0; waitc++;
                end
            end else begin
                d_ack = 1'b0;
            end

            if (done === 1'b1) begin
                finished = 1'b1;
                checks += 3;
                if (cyc != exp_done) begin
                    errors++;
                    $display("FAIL %s done latency: got %0d expected %0d", name, cyc, exp_done);
                end
                if (err !== exp_err) begin
                    errors++;
                    $display("FAIL %s err: got %b expected %b", name, err, exp_err);
                end
                if (bi != exp_bi) begin
                    errors++;
                    $display("FAIL %s beats completed: got %0d expected %0d", name, bi, exp_bi);
                end
            end
        end

        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s no done within 300 cycles", name);
        end
        d_ack = 1'b0;

        for (int c = 0; c < (poke ? 4 : 1); c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || d_we !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL %s idle after done: got done=%b busy=%b d_we=%b err=%b expected all 0",
                         name, done, busy, d_we, err);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; d_ack = 1'b0;
        opcode = '0; funct3 = '0; imm = '0; in1 = '0; in2 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, d_we, d_be, d_addr, d_wdata} !== '0) begin
            errors++;
            $display("FAIL reset state: got busy=%b done=%b err=%b d_we=%b be=%b addr=%h wdata=%h expected all 0",
                     busy, done, err, d_we, d_be, d_addr, d_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sw_aligned();
        do_store("sw_aligned", 7'b0100011, 3'b010, 12'h004, 32'h0000_1000, 32'hDEAD_BEEF, 0, 1'b0);
    endtask

    task automatic test_sb();
        do_store("sb_lane3", 7'b0100011, 3'b000, 12'h000, 32'h0000_2003, 32'h0000_00A5, 0, 1'b0);
    endtask

    task automatic test_split_sh();
        do_store("sh_split", 7'b0100011, 3'b001, 12'hFFF, 32'h0000_3000, 32'h1234_BEEF, 0, 1'b0);
    endtask

    task automatic test_wrap();
        do_store("sw_wrap", 7'b0100011, 3'b010, 12'h000, 32'hFFFF_FFFE, 32'h1122_3344, 0, 1'b0);
        do_store("sw_wrap_slow", 7'b0100011, 3'b010, 12'h7FF, 32'hFFFF_F7FF, 32'h5566_7788, 2, 1'b0);
    endtask

    task automatic test_timeout();
        do_store("timeout", 7'b0100011, 3'b010, 12'h010, 32'h0000_4000, 32'hCAFE_F00D, 1000, 1'b0);
        do_store("ack_last_cycle", 7'b0100011, 3'b000, 12'h001, 32'h0000_4000, 32'h0000_0077, T - 1, 1'b0);
    endtask

    task automatic test_illegal();
        do_store("illegal_f3", 7'b0100011, 3'b011, 12'h000, 32'h0000_5000, 32'h0BAD_0BAD, 0, 1'b0);
        do_store("illegal_op", 7'b0000011, 3'b010, 12'h000, 32'h0000_5000, 32'h0BAD_0BAD, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_store("start_busy", 7'b0100011, 3'b010, 12'h008, 32'h0000_6000, 32'hA5A5_5A5A, 3, 1'b1);
        do_store("b2b_1", 7'b0100011, 3'b001, 12'h002, 32'h0000_6001, 32'h0000_C3D4, 0, 1'b0);
        do_store("b2b_2", 7'b0100011, 3'b000, 12'hFFE, 32'h0000_6001, 32'h0000_0042, 1, 1'b0);
    endtask

    task automatic test_reset_mid_beat();
        @(negedge clk);
        opcode = 7'b0100011; funct3 = 3'b010; imm = 12'h000; in1 = 32'h0000_7002; in2 = 32'h89AB_CDEF;
        start = 1'b1; d_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (d_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid pre-reset d_we: got %b expected 1", d_we);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, err, d_we, d_be, d_addr, d_wdata} !== '0) begin
            errors++;
            $display("FAIL rst_mid outputs: got busy=%b done=%b err=%b d_we=%b be=%b addr=%h wdata=%h expected all 0",
                     busy, done, err, d_we, d_be, d_addr, d_wdata);
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || d_we !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid after reset cyc%0d: got done=%b d_we=%b busy=%b expected 0", c, done, d_we, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] op;
        logic [2:0] f3;
        int         dly;
        for (int n = 0; n < 40; n++) begin
            op  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'b0100011;
            f3  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            dly = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 3));
            do_store("random", op, f3, 12'($urandom), $urandom, $urandom, dly, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_sw_aligned();
        test_sb();
        test_split_sh();
        test_wrap();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_mid_beat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
